inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 84 ++++++++
 tb/tb_inst_fetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers (pc, inst) pairs between the PC stage and decode.
// Head entry is registered; flush empties the queue at the next edge.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic [AW-1:0]            pc,
    input  logic [DW-1:0]            inst_i,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     fetch_stall,
    output logic                     id_valid,
    output logic [AW-1:0]            id_pc,
    output logic [DW-1:0]            id_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // A full queue never pushes, even when it pops in the same cycle.
    assign push = ce & ~flush & ~full;
    assign pop  = id_valid & id_ready;

    assign fetch_stall = full;
    assign id_valid    = ~empty & ~flush;
    assign count       = cnt;

    assign id_pc   = id_valid ? pc_mem[rd_ptr]   : '0;
    assign id_inst = id_valid ? inst_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc;
            inst_mem[wr_ptr] <= inst_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the fetch buffer.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst_i;
    logic        flush;
    logic        id_ready;
    logic        fetch_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .pc          (pc),
        .inst_i      (inst_i),
        .flush       (flush),
        .id_ready    (id_ready),
        .fetch_stall (fetch_stall),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mpc[$];
    logic [31:0] minst[$];
    logic [31:0] rx_pc[$];
    logic [31:0] rx_inst[$];

    logic        o_valid, o_stall, e_valid, e_stall;
    logic [2:0]  o_count, e_count;
    logic [31:0] o_pc, o_inst, e_pc, e_inst;

    function automatic string obs_str();
        return $sformatf("got v=%b s=%b c=%0d pc=%h i=%h, exp v=%b s=%b c=%0d pc=%h i=%h",
                         o_valid, o_stall, o_count, o_pc, o_inst,
                         e_valid, e_stall, e_count, e_pc, e_inst);
    endfunction

    // Drive one cycle, sample at the falling edge, then advance the model.
    task automatic step(input logic c, input logic [31:0] p, input logic [31:0] i,
                        input logic f, input logic r);
        bit full_now;
        ce = c; pc = p; inst_i = i; flush = f; id_ready = r;
        @(negedge clk);
        o_valid = id_valid; o_stall = fetch_stall; o_count = count;
        o_pc = id_pc; o_inst = id_inst;
        e_valid = (mpc.size() != 0) && !f;
        e_pc    = e_valid ? mpc[0] : 32'h0;
        e_inst  = e_valid ? minst[0] : 32'h0;
        e_count = 3'(mpc.size());
        e_stall = (mpc.size() == DEPTH);
        if (o_valid && r) begin
            rx_pc.push_back(o_pc);
            rx_inst.push_back(o_inst);
        end
        if (f) begin
            mpc.delete();
            minst.delete();
        end else begin
            full_now = (mpc.size() == DEPTH);
            if (e_valid && r) begin
                void'(mpc.pop_front());
                void'(minst.pop_front());
            end
            if (c && !full_now) begin
                mpc.push_back(p);
                minst.push_back(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b1; pc = 32'h44; inst_i = 32'hdead;
        flush = 1'b0; id_ready = 1'b1;
        #2;
        checks++;
        if ({id_valid, fetch_stall, count, id_pc, id_inst} !== 68'h0) begin
            errors++;
            $display("FAIL reset_async: got v=%b s=%b c=%0d pc=%h i=%h, exp all zero",
                     id_valid, fetch_stall, count, id_pc, id_inst);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold_count: got %0d exp 0", count);
        end
        rst = 1'b1;
        mpc.delete(); minst.delete();
        step(1'b1, 32'h100, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_inst !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_first_push: %s", obs_str());
        end
    endtask

    task automatic test_ce_gating();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h500 + 32'(k), $urandom, 1'b0, 1'b1);
            checks++;
            if (o_count !== 3'd0 || o_valid !== 1'b0 || e_count !== 3'd0) begin
                errors++;
                $display("FAIL ce_gating cyc %0d: %s", k, obs_str());
            end
        end
    endtask

    task automatic test_fill_full();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'(k * 4), $urandom, 1'b0, 1'b0);
            checks++;
            if ({o_valid, o_stall, o_count, o_pc, o_inst} !==
                {e_valid, e_stall, e_count, e_pc, e_inst}) begin
                errors++;
                $display("FAIL fill cyc %0d: %s", k, obs_str());
            end
        end
        checks++;
        if (o_count !== 3'd4 || o_stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got c=%0d s=%b exp c=4 s=1", o_count, o_stall);
        end
        step(1'b1, 32'h10, $urandom, 1'b0, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_pop_head: got v=%b pc=%h exp v=1 pc=0", o_valid, o_pc);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (o_count !== 3'd3 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_count: got c=%0d s=%b exp c=3 s=0", o_count, o_stall);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            checks++;
            if ({o_valid, o_stall, o_count, o_pc, o_inst} !==
                {e_valid, e_stall, e_count, e_pc, e_inst}) begin
                errors++;
                $display("FAIL full_drain cyc %0d: %s", k, obs_str());
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h40, $urandom, 1'b0, 1'b0);
        step(1'b1, 32'h44, $urandom, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h48 + 32'(k * 4), $urandom, 1'b0, 1'b1);
            checks++;
            if (o_count !== 3'd2 || o_valid !== 1'b1 || o_pc !== 32'h40 + 32'(k * 4) ||
                o_inst !== e_inst) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: %s (exp pc %h)", k, obs_str(),
                         32'h40 + 32'(k * 4));
            end
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (o_count !== 3'd2 || o_pc !== 32'h4c) begin
            errors++;
            $display("FAIL back_to_back_end: got c=%0d pc=%h exp c=2 pc=4c", o_count, o_pc);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h200 + 32'(k * 4), $urandom, 1'b0, 1'b0);
        end
        step(1'b1, 32'h300, 32'hbeef, 1'b1, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd3 || o_pc !== 32'h0) begin
            errors++;
            $display("FAIL flush_cycle: got v=%b c=%0d pc=%h exp v=0 c=3 pc=0",
                     o_valid, o_count, o_pc);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o_count !== 3'd0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got c=%0d v=%b exp c=0 v=0", o_count, o_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h600 + 32'(k * 4), $urandom, 1'b0, 1'b0);
        end
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_pre: got c=%0d exp 3", count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || count !== 3'd0 || id_pc !== 32'h0 || fetch_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b c=%0d pc=%h s=%b exp all zero",
                     id_valid, count, id_pc, fetch_stall);
        end
        mpc.delete(); minst.delete();
        #1;
        rst = 1'b1;
        step(1'b1, 32'h20, 32'h0bad_cafe, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h20 || o_inst !== 32'h0bad_cafe) begin
            errors++;
            $display("FAIL reset_mid_push: %s", obs_str());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] sp[10];
        logic [31:0] si[10];
        int idx = 0;
        logic rdy = 1'b0;
        logic c;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rx_pc.delete(); rx_inst.delete();
        for (int k = 0; k < 10; k++) begin
            sp[k] = 32'(k * 4);
            si[k] = $urandom;
        end
        for (int cyc = 0; cyc < 100 && rx_pc.size() < 10; cyc++) begin
            c = (idx < 10);
            step(c, c ? sp[idx] : 32'h0, c ? si[idx] : 32'h0, 1'b0, rdy);
            checks++;
            if ({o_valid, o_stall, o_count, o_pc, o_inst} !==
                {e_valid, e_stall, e_count, e_pc, e_inst}) begin
                errors++;
                $display("FAIL wrap cyc %0d: %s", cyc, obs_str());
            end
            if (c && !o_stall) idx++;
            rdy = ~rdy;
        end
        checks++;
        if (rx_pc.size() != 10) begin
            errors++;
            $display("FAIL wrap_count: got %0d entries exp 10", rx_pc.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (rx_pc[k] !== sp[k] || rx_inst[k] !== si[k]) begin
                    errors++;
                    $display("FAIL wrap_order %0d: got pc=%h i=%h exp pc=%h i=%h",
                             k, rx_pc[k], rx_inst[k], sp[k], si[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] next_pc = 32'h1000;
        logic c, f, r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            c = ($urandom_range(3) != 0);
            f = ($urandom_range(15) == 0);
            r = ($urandom_range(1) == 1);
            step(c, next_pc, $urandom, f, r);
            checks++;
            if ({o_valid, o_stall, o_count, o_pc, o_inst} !==
                {e_valid, e_stall, e_count, e_pc, e_inst}) begin
                errors++;
                $display("FAIL random cyc %0d: %s", cyc, obs_str());
            end
            if (c && !o_stall && !f) next_pc = next_pc + 32'h4;
        end
    endtask

    initial begin
        test_reset();
        test_ce_gating();
        test_fill_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
